// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Consumed by multicycle_control_unit and mc_alu_decoder.
package multicycle_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decoder: maps ALUOp/funct3/funct7b5/op[5] to the 3-bit ALUControl.
// EXT_ALU=0 folds xor/sll/srl back onto add.
module mc_alu_decoder
    import multicycle_ctrl_pkg::*;
#(
    parameter bit EXT_ALU = 1'b1
) (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) may subtract; addi ignores IR[30].
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = EXT_ALU ? ALU_SLL : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = EXT_ALU ? ALU_XOR : ALU_ADD;
                    3'b101:  alu_control = EXT_ALU ? ALU_SRL : ALU_ADD;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for the multicycle RV32I datapath with branch resolution.
// Define CU_ILLEGAL_TRAP_EN to trap unknown opcodes instead of treating them as NOPs.
module multicycle_control_unit
    import multicycle_ctrl_pkg::*;
#(
    parameter bit BRANCH_EXT = 1'b1,
    parameter bit EXT_ALU    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       taken;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = BRANCH_EXT && !zero;
            3'b100:  taken = BRANCH_EXT && lt;
            3'b101:  taken = BRANCH_EXT && !lt;
            3'b110:  taken = BRANCH_EXT && ltu;
            3'b111:  taken = BRANCH_EXT && !ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        alu_op     = ALUOP_ADD;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes OldPC + imm so BRANCH/JAL find the target in ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_next = S_TRAP;
`else
                        state_next = S_FETCH;
                        instr_done = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_A;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                alu_op     = ALUOP_SUB;
                PCWrite    = taken;
                instr_done = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
`ifdef CU_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal    = 1'b1;
                state_next = S_TRAP;
            end
`endif
            default: state_next = S_FETCH;
        endcase
        // Reset cycle: no enables, selects parked at their FETCH values.
        if (rst) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            ResultSrc  = RES_ALURESULT;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign ImmSrc = imm_src(op);

    mc_alu_decoder #(
        .EXT_ALU(EXT_ALU)
    ) u_alu_dec (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alu_control(ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: two configurations (full and reduced) driven in lockstep,
// compared every cycle against an instruction-level reference model.
module tb_multicycle_control_unit;

    typedef logic [17:0] vec_t;
    typedef vec_t vq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;

    logic a_pcw, a_adr, a_memw, a_irw, a_regw, a_done, a_ill;
    logic [1:0] a_rs, a_sa, a_sb, a_imm;
    logic [2:0] a_alu;
    logic b_pcw, b_adr, b_memw, b_irw, b_regw, b_done, b_ill;
    logic [1:0] b_rs, b_sa, b_sb, b_imm;
    logic [2:0] b_alu;

    int vectors = 0;
    int miscompares = 0;

`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP_BUILD = 1'b1;
`else
    localparam bit TRAP_BUILD = 1'b0;
`endif

    always #5 clk = ~clk;

    multicycle_control_unit #(.BRANCH_EXT(1'b1), .EXT_ALU(1'b1)) u_dut_full (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu),
        .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_memw), .IRWrite(a_irw),
        .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ImmSrc(a_imm),
        .ALUControl(a_alu), .RegWrite(a_regw), .instr_done(a_done), .illegal(a_ill)
    );

    multicycle_control_unit #(.BRANCH_EXT(1'b0), .EXT_ALU(1'b0)) u_dut_min (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu),
        .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_memw), .IRWrite(b_irw),
        .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ImmSrc(b_imm),
        .ALUControl(b_alu), .RegWrite(b_regw), .instr_done(b_done), .illegal(b_ill)
    );

    wire vec_t obs_a = {a_pcw, a_adr, a_memw, a_irw, a_rs, a_sa, a_sb, a_imm, a_alu, a_regw, a_done, a_ill};
    wire vec_t obs_b = {b_pcw, b_adr, b_memw, b_irw, b_rs, b_sa, b_sb, b_imm, b_alu, b_regw, b_done, b_ill};

    function automatic logic [1:0] ref_imm(input logic [6:0] o);
        if (o == 7'b0100011)      return 2'b01;
        else if (o == 7'b1100011) return 2'b10;
        else if (o == 7'b1101111) return 2'b11;
        else                      return 2'b00;
    endfunction

    // Operation the ALU should perform for a funct-decoded instruction.
    function automatic logic [2:0] ref_alu(input bit is_r, input logic [2:0] f3, input bit f7, input bit ext);
        case (f3)
            3'd0:    return (is_r && f7) ? 3'b001 : 3'b000;
            3'd1:    return ext ? 3'b110 : 3'b000;
            3'd2:    return 3'b101;
            3'd4:    return ext ? 3'b100 : 3'b000;
            3'd5:    return ext ? 3'b111 : 3'b000;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input bit z, input bit l, input bit lu, input bit bext);
        bit t;
        case (f3)
            3'd0:    t = z;
            3'd1:    t = !z;
            3'd4:    t = l;
            3'd5:    t = !l;
            3'd6:    t = lu;
            3'd7:    t = !lu;
            default: t = 1'b0;
        endcase
        if (!bext && f3 != 3'd0) t = 1'b0;
        return t;
    endfunction

    function automatic vec_t mk(input bit pcw, adr, memw, irw, input logic [1:0] rs, sa, sb, imm,
                                input logic [2:0] alu, input bit regw, done, ill);
        return {pcw, adr, memw, irw, rs, sa, sb, imm, alu, regw, done, ill};
    endfunction

    function automatic vec_t rst_vec(input logic [6:0] o);
        return mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ref_imm(o), 3'b000, 0, 0, 0);
    endfunction

    // Expected per-cycle output bundle for one instruction, starting at FETCH.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input bit f7, z, l, lu,
                         input bit bext, ext, output vq_t q);
        logic [1:0] im;
        vec_t aluwb;
        im = ref_imm(o);
        aluwb = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 1, 1, 0);
        q = {};
        q.push_back(mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, im, 3'b000, 0, 0, 0));
        case (o)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111:
                q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, 0, 0, 0));
            default:
                q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, 0, !TRAP_BUILD, 0));
        endcase
        case (o)
            7'b0000011: begin
                q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, 0, 0));
                q.push_back(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0, 0));
                q.push_back(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, im, 3'b000, 1, 1, 0));
            end
            7'b0100011: begin
                q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, 0, 0));
                q.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 1, 0));
            end
            7'b0110011: begin
                q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, ref_alu(1, f3, f7, ext), 0, 0, 0));
                q.push_back(aluwb);
            end
            7'b0010011: begin
                q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, ref_alu(0, f3, f7, ext), 0, 0, 0));
                q.push_back(aluwb);
            end
            7'b1100011:
                q.push_back(mk(ref_taken(f3, z, l, lu, bext), 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 3'b001, 0, 1, 0));
            7'b1101111: begin
                q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 3'b000, 0, 0, 0));
                q.push_back(aluwb);
            end
            default:
                if (TRAP_BUILD)
                    for (int k = 0; k < 10; k++)
                        q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0, 1));
        endcase
    endtask

    task automatic check(input string tag, input int step, input vec_t obs, input vec_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed %b required %b", tag, step, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH; abort_at >= 0 raises rst in that cycle.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input bit f7, z, l, lu, input int abort_at);
        vq_t qa, qb;
        build(o, f3, f7, z, l, lu, 1'b1, 1'b1, qa);
        build(o, f3, f7, z, l, lu, 1'b0, 1'b0, qb);
        op = o; funct3 = f3; funct7b5 = f7; zero = z; lt = l; ltu = lu;
        for (int i = 0; i < qa.size(); i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check({tag, "/abort_full"}, i, obs_a, rst_vec(o));
                check({tag, "/abort_min"}, i, obs_b, rst_vec(o));
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            check({tag, "/full"}, i, obs_a, qa[i]);
            check({tag, "/min"}, i, obs_b, qb[i]);
            @(posedge clk); #1;
        end
        if (TRAP_BUILD && qa.size() > 2 && qa[2][0]) begin
            rst = 1'b1;
            @(negedge clk);
            check({tag, "/trap_rst_full"}, 0, obs_a, rst_vec(o));
            check({tag, "/trap_rst_min"}, 0, obs_b, rst_vec(o));
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    function automatic bit is_known(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    initial begin
        logic [6:0] ops [6];
        logic [6:0] o;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;

        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_c1_full", 0, obs_a, rst_vec(op));
        check("reset_c1_min", 0, obs_b, rst_vec(op));
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_c2_full", 1, obs_a, rst_vec(op));
        check("reset_c2_min", 1, obs_b, rst_vec(op));
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr("lw",        7'b0000011, 3'b010, 0, 0, 0, 0, -1);
        run_instr("sub",       7'b0110011, 3'b000, 1, 0, 0, 0, -1);
        run_instr("addi_f7",   7'b0010011, 3'b000, 1, 0, 0, 0, -1);
        run_instr("xor",       7'b0110011, 3'b100, 0, 0, 0, 0, -1);
        run_instr("srli",      7'b0010011, 3'b101, 0, 0, 0, 0, -1);
        run_instr("bne_nz",    7'b1100011, 3'b001, 0, 0, 0, 0, -1);
        run_instr("bne_z",     7'b1100011, 3'b001, 0, 1, 0, 0, -1);
        run_instr("beq_z",     7'b1100011, 3'b000, 0, 1, 0, 0, -1);
        run_instr("bltu",      7'b1100011, 3'b110, 0, 0, 0, 1, -1);
        run_instr("jal",       7'b1101111, 3'b000, 0, 0, 0, 0, -1);
        run_instr("sw",        7'b0100011, 3'b010, 0, 0, 0, 0, -1);
        run_instr("sw_abort",  7'b0100011, 3'b010, 0, 0, 0, 0, 3);
        run_instr("lw_after",  7'b0000011, 3'b010, 0, 0, 0, 0, -1);
        run_instr("illegal7f", 7'b1111111, 3'b000, 0, 0, 0, 0, -1);
        run_instr("add_after", 7'b0110011, 3'b000, 0, 0, 0, 0, -1);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                o = 7'($urandom_range(0, 127));
                while (is_known(o)) o = 7'($urandom_range(0, 127));
            end else begin
                o = ops[$urandom_range(0, 5)];
            end
            run_instr("rand", o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Control unit for the multicycle RV32I datapath. The datapath has one shared instruction/data memory and the IR, OldPC, A/B, ALUOut and Data registers.
- A Moore FSM sequences each instruction over 3-5 cycles.
- An embedded ALU decoder produces ALUControl.
- Branch resolution is generalised to all six RV32I branch conditions.
- The datapath instantiates this block in place of the single-cycle control top.

Parameters:
BRANCH_EXT, 1, 1 = decode beq/bne/blt/bge/bltu/bgeu; 0 = beq only, other branch funct3 never taken
EXT_ALU, 1, 1 = decode xor/sll/srl(i); 0 = those funct3 values map to add
STATE_W, 4, state register width (fixed by package, ≥4)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
op  in  7  instruction opcode (IR[6:0])
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2 (from ALU compare)
ltu  in  1  unsigned rs1 < rs2
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut/Result
MemWrite  out  1  memory write enable
IRWrite  out  1  IR/OldPC load enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A
ALUSrcB  out  2  00 = B, 01 = ImmExt, 10 = constant 4
ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
RegWrite  out  1  register file write enable
instr_done  out  1  one-cycle pulse in the final state of each instruction
illegal  out  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- On a clk edge with rst=1, state <= FETCH.
- While rst=1, PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced to 0. The mux selects take their FETCH values.
- Outputs are combinational from the state register, except PCWrite in BRANCH, which also depends on funct3/zero/lt/ltu. Instruction latency counts from FETCH inclusive.
- States and actions (unlisted outputs are 0/00; ALUOp is internal: 00 add, 01 sub, 10 funct-decoded):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute). Next state by op:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other op → ILLEGAL handling (see Optional Feature)
  - MEMADR: ALUSrcA=10, ALUSrcB=01. Next: MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next: FETCH. Load total = 5 cycles.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, instr_done=1. Next: FETCH. Store = 4 cycles.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next: FETCH. R/I/JAL = 4 cycles.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=taken, instr_done=1. Next: FETCH. Branch = 3 cycles.
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1. Next: ALUWB.
- taken by funct3:
  - 000 → zero
  - 001 → !zero
  - 100 → lt
  - 101 → !lt
  - 110 → ltu
  - 111 → !ltu
  - 010/011 → 0
  - With BRANCH_EXT=0, only 000 can be taken.
- ImmSrc is decoded from op in every state:
  - 0000011 / 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - else 00
- ALU decode:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10, by funct3: 000 → sub if (op[5] & funct7b5) else add; 010 → slt; 110 → or; 111 → and; 100 → xor; 001 → sll; 101 → srl.
  - xor/sll/srl decode to add when EXT_ALU=0.
  - Unlisted funct3 → add.
- Asserting rst mid-instruction in any state aborts the instruction. No write enable is asserted in the reset cycle.

Optional Feature:
CU_ILLEGAL_TRAP_EN
- Defined: an unknown op in DECODE → TRAP state.
  - TRAP drives all enables 0 and illegal=1.
  - The FSM holds in TRAP until rst.
- Undefined: an unknown op in DECODE → FETCH (acts as a 2-cycle NOP), with instr_done=1 in DECODE. illegal is tied 0.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - the state enum (STATE_W=4)
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL)
  - ALUOp codes and the ALUControl encodings
  - ResultSrc/ALUSrcA/ALUSrcB select constants
- One sub-module: mc_alu_decoder (combinational: ALUOp, funct3, funct7b5, op[5] → ALUControl; EXT_ALU passed down). FSM, branch resolution and ImmSrc decode stay in the top.

Test Plan:
- rst=1 for 2 cycles, then 0 → first cycle FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10; no enables during rst.
- lw (op 0000011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; instr_done pulses once.
- sub (op 0110011, funct3 000, funct7b5=1) → ALUControl=001 in EXECR. addi with funct7b5=1 (op 0010011) → ALUControl=000.
- bne (funct3 001), zero=0 → PCWrite=1 in BRANCH. zero=1 → PCWrite=0. Repeat with BRANCH_EXT=0 → PCWrite=0 in both cases.
- rst asserted in MEMWRITE cycle → MemWrite=0 that cycle; next state FETCH.
- op 1111111 → with CU_ILLEGAL_TRAP_EN: illegal=1 and held for 10 cycles until rst. Without the macro: back to FETCH after DECODE, illegal=0.
